// File: rtl/aes_slot_sched.sv
// aes_slot_sched: slot scheduler for a time-interleaved AES core.
// Tracks which of the N rotating core slots hold a block, arbitrates two
// requesters round-robin into free slots, and reports each retiring block
// with the id/tag it was issued with.
module aes_slot_sched #(
    parameter int N = 4,
    parameter int W = 2,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           drain,
    input  logic [1:0]     req_valid,
    input  logic [2*W-1:0] req_tag,
    output logic [1:0]     req_ready,
    input  logic           core_accept,
    input  logic           core_done,
    output logic           core_load,
    output logic           core_src,
    output logic           resp_valid,
    output logic           resp_id,
    output logic [W-1:0]   resp_tag,
    output logic [PW-1:0]  slot_ptr,
    output logic [N-1:0]   slot_busy,
    output logic           drained,
    output logic           err_spurious
);

    logic [N-1:0]         slot_id;
    logic [N-1:0][W-1:0]  slot_tag;
    logic                 prio;

    logic                 busy_s;
    logic                 slot_free;
    logic                 grant;
    logic                 win;
    logic                 retire;
    logic                 spurious;
    logic [W-1:0]         win_tag;

    // Grant/retire decode for the slot currently at the core output.
    // A slot retiring this cycle counts as free so it can be refilled at once.
    always_comb begin
        busy_s    = slot_busy[slot_ptr];
        slot_free = ~busy_s | core_done;
        grant     = start & core_accept & ~drain & slot_free & (|req_valid);
        win       = (&req_valid) ? prio : req_valid[1];
        win_tag   = win ? req_tag[2*W-1:W] : req_tag[W-1:0];
        retire    = core_done & busy_s;
        spurious  = core_done & ~busy_s;
        req_ready = 2'b00;
        if (grant) req_ready = win ? 2'b10 : 2'b01;
        core_load = grant;
        core_src  = grant & win;
        drained   = drain & ~(|slot_busy);
    end

    // Slot pointer rotation, round-robin priority and sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_ptr     <= '0;
            prio         <= 1'b0;
            err_spurious <= 1'b0;
        end else begin
            if (start)
                slot_ptr <= (slot_ptr == PW'(N-1)) ? '0 : slot_ptr + PW'(1);
            if (grant)
                prio <= ~win;
            if (spurious)
                err_spurious <= 1'b1;
        end
    end

    // Per-slot occupancy and owner record; a grant on a retiring slot keeps
    // it busy and overwrites the owner.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_busy <= '0;
            slot_id   <= '0;
            slot_tag  <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (slot_ptr == PW'(i)) begin
                    if (grant) begin
                        slot_busy[i] <= 1'b1;
                        slot_id[i]   <= win;
                        slot_tag[i]  <= win_tag;
                    end else if (retire) begin
                        slot_busy[i] <= 1'b0;
                    end
                end
            end
        end
    end

    // Registered response: one cycle after a retiring core_done, the old owner.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid <= 1'b0;
            resp_id    <= 1'b0;
            resp_tag   <= '0;
        end else begin
            resp_valid <= retire;
            if (retire) begin
                resp_id  <= slot_id[slot_ptr];
                resp_tag <= slot_tag[slot_ptr];
            end
        end
    end

endmodule

// File: tb/tb_aes_slot_sched.sv
// Self-checking bench for aes_slot_sched: a cycle model predicts grants and
// pushes expected responses to a queue; a monitor pops and compares them.
module tb_aes_slot_sched;

    localparam int N = 4;
    localparam int W = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic           drain;
    logic [1:0]     req_valid;
    logic [2*W-1:0] req_tag;
    logic [1:0]     req_ready;
    logic           core_accept;
    logic           core_done;
    logic           core_load;
    logic           core_src;
    logic           resp_valid;
    logic           resp_id;
    logic [W-1:0]   resp_tag;
    logic [1:0]     slot_ptr;
    logic [N-1:0]   slot_busy;
    logic           drained;
    logic           err_spurious;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct packed {
        logic         id;
        logic [W-1:0] tag;
    } resp_t;

    resp_t exp_q[$];

    // reference model state
    int           m_ptr  = 0;
    logic [N-1:0] m_busy = '0;
    logic         m_prio = 1'b0;
    logic [N-1:0] m_id   = '0;
    logic [W-1:0] m_tag [N];

    aes_slot_sched #(.N(N), .W(W)) dut (
        .clk(clk), .rst(rst), .start(start), .drain(drain),
        .req_valid(req_valid), .req_tag(req_tag), .req_ready(req_ready),
        .core_accept(core_accept), .core_done(core_done),
        .core_load(core_load), .core_src(core_src),
        .resp_valid(resp_valid), .resp_id(resp_id), .resp_tag(resp_tag),
        .slot_ptr(slot_ptr), .slot_busy(slot_busy), .drained(drained),
        .err_spurious(err_spurious)
    );

    always #5 clk = ~clk;

    // model: advance state at each rising edge from the inputs seen there
    always @(posedge clk) begin : model
        logic mfree, mg, mw;
        if (rst) begin
            m_ptr  <= 0;
            m_busy <= '0;
            m_prio <= 1'b0;
            m_id   <= '0;
            for (int i = 0; i < N; i++) m_tag[i] <= '0;
            exp_q.delete();
        end else begin
            mfree = !m_busy[m_ptr] || core_done;
            mg    = start && core_accept && !drain && mfree && (req_valid != 2'b00);
            mw    = (req_valid == 2'b11) ? m_prio : req_valid[1];
            if (core_done && m_busy[m_ptr])
                exp_q.push_back({m_id[m_ptr], m_tag[m_ptr]});
            if (mg) begin
                m_busy[m_ptr] <= 1'b1;
                m_id[m_ptr]   <= mw;
                m_tag[m_ptr]  <= mw ? req_tag[2*W-1:W] : req_tag[W-1:0];
                m_prio        <= !mw;
            end else if (core_done && m_busy[m_ptr]) begin
                m_busy[m_ptr] <= 1'b0;
            end
            if (start) m_ptr <= (m_ptr == N-1) ? 0 : m_ptr + 1;
        end
    end

    // monitor: compare grant outputs and pop the response scoreboard
    always @(negedge clk) begin : monitor
        logic efree, eg, ew;
        logic [1:0] er;
        resp_t e;
        efree = !m_busy[m_ptr] || core_done;
        eg    = start && core_accept && !drain && efree && (req_valid != 2'b00);
        ew    = (req_valid == 2'b11) ? m_prio : req_valid[1];
        er    = eg ? (ew ? 2'b10 : 2'b01) : 2'b00;
        n_checks++;
        if (req_ready !== er || core_load !== eg || core_src !== (eg & ew)) begin
            n_err++;
            $display("FAIL mon_grant t=%0t got ready=%b load=%b src=%b want ready=%b load=%b src=%b",
                     $time, req_ready, core_load, core_src, er, eg, eg & ew);
        end
        n_checks++;
        if (drained !== (drain && m_busy == '0)) begin
            n_err++;
            $display("FAIL mon_drained t=%0t got %b want %b", $time, drained, drain && m_busy == '0);
        end
        n_checks++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (resp_valid !== 1'b1 || resp_id !== e.id || resp_tag !== e.tag) begin
                n_err++;
                $display("FAIL mon_resp t=%0t got v=%b id=%b tag=%0d want v=1 id=%b tag=%0d",
                         $time, resp_valid, resp_id, resp_tag, e.id, e.tag);
            end
        end else if (resp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL mon_resp_spurious t=%0t got resp_valid=%b want 0", $time, resp_valid);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    // rotate the slot pointer without granting until the model sits on slot k
    task automatic goto_slot(input int k);
        start = 1'b1; core_accept = 1'b0; core_done = 1'b0;
        for (int i = 0; i <= N && m_ptr != k; i++) cyc();
        n_checks++;
        if (m_ptr != k || slot_ptr !== 2'(k)) begin
            n_err++;
            $display("FAIL goto_slot got %0d want %0d", slot_ptr, k);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; drain = 1'b1; req_valid = 2'b11;
        req_tag = '0; core_accept = 1'b1; core_done = 1'b0;
        cyc(); cyc();
        n_checks++;
        if (slot_ptr !== 2'd0 || slot_busy !== 4'b0000 || resp_valid !== 1'b0 ||
            resp_id !== 1'b0 || resp_tag !== 2'd0 || err_spurious !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state got ptr=%0d busy=%b rv=%b id=%b tag=%0d err=%b want all 0",
                     slot_ptr, slot_busy, resp_valid, resp_id, resp_tag, err_spurious);
        end
        n_checks++;
        if (req_ready !== 2'b00 || core_load !== 1'b0 || core_src !== 1'b0 || drained !== 1'b1) begin
            n_err++;
            $display("FAIL reset_comb got ready=%b load=%b src=%b drained=%b want 00 0 0 1",
                     req_ready, core_load, core_src, drained);
        end
        rst = 1'b0; drain = 1'b0; req_valid = 2'b00; core_accept = 1'b0;
        cyc();
    endtask

    task automatic test_single_issue();
        start = 1'b1; core_accept = 1'b1; req_valid = 2'b01; req_tag = {2'd0, 2'd2};
        #1;
        n_checks++;
        if (req_ready !== 2'b01 || core_load !== 1'b1 || core_src !== 1'b0) begin
            n_err++;
            $display("FAIL single_grant got ready=%b load=%b src=%b want 01 1 0",
                     req_ready, core_load, core_src);
        end
        cyc();
        n_checks++;
        if (slot_busy !== 4'b0001) begin
            n_err++;
            $display("FAIL single_busy got %b want 0001", slot_busy);
        end
        req_valid = 2'b00;
        goto_slot(0);
        core_done = 1'b1;
        cyc();
        n_checks++;
        if (resp_valid !== 1'b1 || resp_id !== 1'b0 || resp_tag !== 2'd2 || slot_busy !== 4'b0000) begin
            n_err++;
            $display("FAIL single_resp got v=%b id=%b tag=%0d busy=%b want 1 0 2 0000",
                     resp_valid, resp_id, resp_tag, slot_busy);
        end
        core_done = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [3:0] want_src;
        want_src = 4'b1010;  // grant i expects bit i: 0,1,0,1
        do_reset();
        start = 1'b1; core_accept = 1'b1; req_valid = 2'b11; req_tag = {2'd2, 2'd1};
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++;
            if (core_src !== want_src[i] || core_load !== 1'b1) begin
                n_err++;
                $display("FAIL rr_grant%0d got src=%b load=%b want %b 1", i, core_src, core_load, want_src[i]);
            end
            cyc();
        end
        n_checks++;
        if (slot_busy !== 4'b1111) begin
            n_err++;
            $display("FAIL rr_busy got %b want 1111", slot_busy);
        end
        req_valid = 2'b00; core_accept = 1'b0;
    endtask

    task automatic test_slot_reuse();
        goto_slot(2);
        core_done = 1'b1; core_accept = 1'b1; req_valid = 2'b10; req_tag = {2'd3, 2'd0};
        #1;
        n_checks++;
        if (req_ready !== 2'b10) begin
            n_err++;
            $display("FAIL reuse_grant got %b want 10", req_ready);
        end
        cyc();
        n_checks++;
        if (resp_valid !== 1'b1 || resp_id !== 1'b0 || resp_tag !== 2'd1 || slot_busy !== 4'b1111) begin
            n_err++;
            $display("FAIL reuse_old got v=%b id=%b tag=%0d busy=%b want 1 0 1 1111",
                     resp_valid, resp_id, resp_tag, slot_busy);
        end
        req_valid = 2'b00;
        goto_slot(2);
        core_done = 1'b1;
        cyc();
        n_checks++;
        if (resp_valid !== 1'b1 || resp_id !== 1'b1 || resp_tag !== 2'd3 || slot_busy !== 4'b1011) begin
            n_err++;
            $display("FAIL reuse_new got v=%b id=%b tag=%0d busy=%b want 1 1 3 1011",
                     resp_valid, resp_id, resp_tag, slot_busy);
        end
        core_done = 1'b0;
    endtask

    task automatic test_drain();
        logic [3:0] want_busy [3];
        want_busy = '{4'b0011, 4'b0010, 4'b0000};
        drain = 1'b1; req_valid = 2'b11; core_accept = 1'b1; start = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 2'b00 || drained !== 1'b0) begin
            n_err++;
            $display("FAIL drain_block got ready=%b drained=%b want 00 0", req_ready, drained);
        end
        core_done = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_checks++;
            if (slot_busy !== want_busy[i] || drained !== (i == 2)) begin
                n_err++;
                $display("FAIL drain_step%0d got busy=%b drained=%b want %b %b",
                         i, slot_busy, drained, want_busy[i], i == 2);
            end
        end
        core_done = 1'b0; drain = 1'b0; req_valid = 2'b00; core_accept = 1'b0;
    endtask

    task automatic test_spurious();
        core_done = 1'b1;
        cyc();
        core_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (resp_valid !== 1'b0 || err_spurious !== 1'b1) begin
                n_err++;
                $display("FAIL spurious%0d got rv=%b err=%b want 0 1", i, resp_valid, err_spurious);
            end
            cyc();
        end
    endtask

    task automatic test_stall_reset();
        goto_slot(1);
        core_accept = 1'b1; req_valid = 2'b01; req_tag = {2'd0, 2'd1};
        cyc();
        req_valid = 2'b10;
        cyc();
        core_accept = 1'b0; req_valid = 2'b00;
        goto_slot(1);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_checks++;
            if (slot_ptr !== 2'd1 || slot_busy !== 4'b0110 || err_spurious !== 1'b1) begin
                n_err++;
                $display("FAIL stall%0d got ptr=%0d busy=%b err=%b want 1 0110 1",
                         i, slot_ptr, slot_busy, err_spurious);
            end
        end
        rst = 1'b1; start = 1'b1; core_done = 1'b1;
        cyc();
        n_checks++;
        if (slot_ptr !== 2'd0 || slot_busy !== 4'b0000 || resp_valid !== 1'b0 ||
            resp_id !== 1'b0 || resp_tag !== 2'd0 || err_spurious !== 1'b0) begin
            n_err++;
            $display("FAIL midreset got ptr=%0d busy=%b rv=%b id=%b tag=%0d err=%b want all 0",
                     slot_ptr, slot_busy, resp_valid, resp_id, resp_tag, err_spurious);
        end
        rst = 1'b0; start = 1'b0; core_done = 1'b0;
        cyc();
        n_checks++;
        if (resp_valid !== 1'b0 || slot_ptr !== 2'd0) begin
            n_err++;
            $display("FAIL midreset_after got rv=%b ptr=%0d want 0 0", resp_valid, slot_ptr);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; drain = 1'b0; req_valid = 2'b00;
        req_tag = '0; core_accept = 1'b0; core_done = 1'b0;
        for (int i = 0; i < N; i++) m_tag[i] = '0;
        test_reset();
        test_single_issue();
        test_round_robin();
        test_slot_reuse();
        test_drain();
        test_spurious();
        test_stall_reset();
        cyc();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_leftover got %0d pending want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

endmodule
